// File: rtl/mul_job_scheduler.sv
// mul_job_scheduler: accepts multiply job descriptors from two requesters,
// arbitrates them round-robin and sequences one job at a time through the
// systolic multiply datapath (mul_top). Completion is reported with the
// requester index and an error flag. The error flag covers illegal
// descriptors and jobs that exceed the watchdog limit.
module mul_job_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int CMD_W          = 142,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
    output logic [2:0]               mem_mode,
    output logic                     calc_init,
    output logic [31:0]              BASE_ADDR_LEFT,
    output logic [31:0]              BASE_ADDR_RIGHT,
    output logic [31:0]              BASE_ADDR_ADDSRC,
    output logic [31:0]              BASE_ADDR_SAVE,
    output logic [10:0]              MATRIX_SIZE,
    input  logic [3:0]               current_state,
    output logic                     busy,
    output logic                     done_valid,
    output logic                     done_id,
    output logic                     done_err
);

    // Descriptor field positions, MSB to LSB: mode, size, left, right, addsrc, save
    localparam int SAVE_LSB   = 0;
    localparam int ADDSRC_LSB = 32;
    localparam int RIGHT_LSB  = 64;
    localparam int LEFT_LSB   = 96;
    localparam int SIZE_LSB   = 128;
    localparam int MODE_LSB   = 139;

    // Watchdog fires on the cycle the count of waiting/running cycles
    // reaches TIMEOUT_CYCLES.
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_START,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    logic [15:0]        timer;
    logic               last_id;   // requester served most recently
    logic               job_id;    // requester owning the job in flight
    logic [NUM_REQ-1:0] grant;
    logic               grant_id;
    logic               handshake;
    logic [CMD_W-1:0]   sel_cmd;
    logic [2:0]         sel_mode;
    logic [10:0]        sel_size;

    // A descriptor is legal when it names one of the four datapath modes
    // and a non-empty matrix.
    function automatic logic desc_legal(input logic [2:0] mode, input logic [10:0] size);
        return (mode >= 3'd1) && (mode <= 3'd4) && (size != 11'd0);
    endfunction

    // Round-robin grant: a lone valid requester wins; on a tie the one not
    // served last wins. Grants are only offered while idle.
    always_comb begin
        grant = '0;
        if (state == S_IDLE) begin
            if (req_valid[0] && req_valid[1]) begin
                grant = last_id ? 2'b01 : 2'b10;
            end else begin
                grant = req_valid;
            end
        end
    end

    assign req_ready = grant;
    assign handshake = |(req_valid & grant);
    assign grant_id  = grant[1];
    assign sel_cmd   = grant_id ? req_cmd[CMD_W +: CMD_W] : req_cmd[0 +: CMD_W];
    assign sel_mode  = sel_cmd[MODE_LSB +: 3];
    assign sel_size  = sel_cmd[SIZE_LSB +: 11];

    // Job sequencer: accept, launch, wait for the datapath to start and
    // finish, then report. All outputs other than req_ready are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            timer            <= '0;
            last_id          <= 1'b1;
            job_id           <= 1'b0;
            mem_mode         <= 3'd0;
            calc_init        <= 1'b0;
            BASE_ADDR_LEFT   <= '0;
            BASE_ADDR_RIGHT  <= '0;
            BASE_ADDR_ADDSRC <= '0;
            BASE_ADDR_SAVE   <= '0;
            MATRIX_SIZE      <= '0;
            busy             <= 1'b0;
            done_valid       <= 1'b0;
            done_id          <= 1'b0;
            done_err         <= 1'b0;
        end else begin
            calc_init  <= 1'b0;
            done_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (handshake) begin
                        last_id <= grant_id;
                        job_id  <= grant_id;
                        busy    <= 1'b1;
                        if (desc_legal(sel_mode, sel_size)) begin
                            mem_mode         <= sel_mode;
                            calc_init        <= 1'b1;
                            BASE_ADDR_LEFT   <= sel_cmd[LEFT_LSB +: 32];
                            BASE_ADDR_RIGHT  <= sel_cmd[RIGHT_LSB +: 32];
                            BASE_ADDR_ADDSRC <= sel_cmd[ADDSRC_LSB +: 32];
                            BASE_ADDR_SAVE   <= sel_cmd[SAVE_LSB +: 32];
                            MATRIX_SIZE      <= sel_size;
                            state            <= S_LAUNCH;
                        end else begin
                            // Rejected jobs never touch the datapath.
                            done_valid <= 1'b1;
                            done_id    <= grant_id;
                            done_err   <= 1'b1;
                            state      <= S_DONE;
                        end
                    end
                end
                S_LAUNCH: begin
                    timer <= '0;
                    state <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (timer == TIMER_LAST) begin
                        mem_mode   <= 3'd0;
                        done_valid <= 1'b1;
                        done_id    <= job_id;
                        done_err   <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        timer <= timer + 16'd1;
                        if (current_state != 4'd0) begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // A datapath finish on the last allowed cycle still
                    // counts as a clean completion.
                    if (current_state == 4'd0) begin
                        mem_mode   <= 3'd0;
                        done_valid <= 1'b1;
                        done_id    <= job_id;
                        done_err   <= 1'b0;
                        state      <= S_DONE;
                    end else if (timer == TIMER_LAST) begin
                        mem_mode   <= 3'd0;
                        done_valid <= 1'b1;
                        done_id    <= job_id;
                        done_err   <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
